// File: rtl/queue_sched_if.sv
// Requester, consumer, cancel and queue-side signals of queue_sched.
// master = the scheduler, slave = the surrounding requesters, consumer and queue.
interface queue_sched_if #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned PTR_WIDTH = 10
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ready;

    logic                         cancel_valid;
    logic [PTR_WIDTH-1:0]         cancel_index;
    logic                         cancel_ready;

    logic                         deq_valid;
    logic [DATA_SIZE-1:0]         deq_data;
    logic                         deq_ready;

    logic                         q_push_flag;
    logic [DATA_SIZE-1:0]         q_push_data;
    logic                         q_pop_flag;
    logic [DATA_SIZE-1:0]         q_pop_data;
    logic                         q_remove_flag;
    logic [PTR_WIDTH-1:0]         q_remove_index;
    logic                         q_full;
    logic                         q_empty;
    logic                         q_error_time;
    logic                         q_error_rem;

    modport master (
        input  req_valid, req_data, cancel_valid, cancel_index, deq_ready,
               q_pop_data, q_full, q_empty, q_error_time, q_error_rem,
        output req_ready, cancel_ready, deq_valid, deq_data,
               q_push_flag, q_push_data, q_pop_flag, q_remove_flag, q_remove_index
    );

    modport slave (
        output req_valid, req_data, cancel_valid, cancel_index, deq_ready,
               q_pop_data, q_full, q_empty, q_error_time, q_error_rem,
        input  req_ready, cancel_ready, deq_valid, deq_data,
               q_push_flag, q_push_data, q_pop_flag, q_remove_flag, q_remove_index
    );
endinterface

// File: rtl/queue_sched.sv
// Round-robin push arbiter plus pop/cancel slot scheduler in front of a queue.
// Define QUEUE_SCHED_STATS_EN to build the saturating push/pop/fail counters.
module queue_sched #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned PTR_WIDTH = 10,
    parameter int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                reset,
    queue_sched_if.master       bus,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                pop_stall,
    output logic                cancel_fail,
    output logic [15:0]         push_count,
    output logic [15:0]         pop_count,
    output logic [15:0]         fail_count
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic {IDLE = 1'b0, CHECK = 1'b1} state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
    logic                prio_q, prio_d;
    logic                chk_rem_q, chk_rem_d;
    logic                pop_stall_q, pop_stall_d;
    logic                cancel_fail_q, cancel_fail_d;

    logic                grant_any;
    logic [ID_WIDTH-1:0] grant_idx;
    logic [ID_WIDTH-1:0] cand;
    logic                push_fire;
    logic                idle;
    logic                pop_cand;
    logic                cancel_owns;
    logic                pop_fire;
    logic                rem_fire;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = rr_ptr_q + ID_WIDTH'(k);
            if (!grant_any && bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign push_fire       = grant_any & ~bus.q_full & ~reset;
    assign bus.req_ready   = push_fire ? (NUM_REQ'(1) << grant_idx) : '0;
    assign bus.q_push_flag = push_fire;
    assign bus.q_push_data = bus.req_data[grant_idx*DATA_SIZE +: DATA_SIZE];

    // Pop and cancel share one slot in IDLE; the prio token breaks ties
    assign idle        = (state_q == IDLE);
    assign pop_cand    = idle & ~bus.q_empty & bus.deq_ready;
    assign cancel_owns = idle & bus.cancel_valid & (~pop_cand | prio_q);

    assign bus.deq_valid      = idle & ~bus.q_empty & ~cancel_owns & ~reset;
    assign bus.deq_data       = bus.q_pop_data;
    assign bus.cancel_ready   = cancel_owns & ~reset;
    assign pop_fire           = bus.deq_valid & bus.deq_ready;
    assign rem_fire           = bus.cancel_valid & bus.cancel_ready;
    assign bus.q_pop_flag     = pop_fire;
    assign bus.q_remove_flag  = rem_fire;
    assign bus.q_remove_index = bus.cancel_index;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        prio_d        = prio_q;
        chk_rem_d     = chk_rem_q;
        pop_stall_d   = pop_stall_q;
        cancel_fail_d = 1'b0;

        if (push_fire) begin
            grant_id_d = grant_idx;
            rr_ptr_d   = grant_idx + ID_WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (pop_fire || rem_fire) begin
                    state_d   = CHECK;
                    chk_rem_d = rem_fire;
                    if (pop_cand && bus.cancel_valid) begin
                        prio_d = ~prio_q;
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (!chk_rem_q && bus.q_error_time) begin
                    pop_stall_d = 1'b1;
                end
                if (chk_rem_q && bus.q_error_rem) begin
                    cancel_fail_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            grant_id_q    <= '0;
            prio_q        <= 1'b0;
            chk_rem_q     <= 1'b0;
            pop_stall_q   <= 1'b0;
            cancel_fail_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            prio_q        <= prio_d;
            chk_rem_q     <= chk_rem_d;
            pop_stall_q   <= pop_stall_d;
            cancel_fail_q <= cancel_fail_d;
        end
    end

    assign grant_id    = grant_id_q;
    assign pop_stall   = pop_stall_q;
    assign cancel_fail = cancel_fail_q;

`ifdef QUEUE_SCHED_STATS_EN
    logic [CNT_W-1:0] push_cnt_q, push_cnt_d;
    logic [CNT_W-1:0] pop_cnt_q, pop_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             err_det;

    assign err_det = (state_q == CHECK) & (chk_rem_q ? bus.q_error_rem : bus.q_error_time);

    // Saturating event counters
    always_comb begin
        push_cnt_d = push_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        fail_cnt_d = fail_cnt_q;
        if (push_fire && (push_cnt_q != '1)) push_cnt_d = push_cnt_q + CNT_W'(1);
        if (pop_fire && (pop_cnt_q != '1))   pop_cnt_d  = pop_cnt_q + CNT_W'(1);
        if (err_det && (fail_cnt_q != '1))   fail_cnt_d = fail_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            push_cnt_q <= '0;
            pop_cnt_q  <= '0;
            fail_cnt_q <= '0;
        end else begin
            push_cnt_q <= push_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign push_count = push_cnt_q;
    assign pop_count  = pop_cnt_q;
    assign fail_count = fail_cnt_q;
`else
    assign push_count = CNT_W'(0);
    assign pop_count  = CNT_W'(0);
    assign fail_count = CNT_W'(0);
`endif

endmodule

// File: tb/tb_queue_sched.sv
// Self-checking bench for queue_sched: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the scheduler.
module tb_queue_sched;
    localparam int unsigned DATA_SIZE = 32;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned PTR_WIDTH = 10;
    localparam int unsigned ID_WIDTH  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [ID_WIDTH-1:0] grant_id;
    logic                pop_stall;
    logic                cancel_fail;
    logic [15:0]         push_count, pop_count, fail_count;

    queue_sched_if #(.DATA_SIZE(DATA_SIZE), .NUM_REQ(NUM_REQ), .PTR_WIDTH(PTR_WIDTH)) bus ();

    queue_sched #(
        .DATA_SIZE(DATA_SIZE), .NUM_REQ(NUM_REQ), .PTR_WIDTH(PTR_WIDTH), .ID_WIDTH(ID_WIDTH)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .grant_id(grant_id), .pop_stall(pop_stall), .cancel_fail(cancel_fail),
        .push_count(push_count), .pop_count(pop_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state
    int m_rr = 0, m_gid = 0, m_push_n = 0, m_pop_n = 0, m_fail_n = 0;
    bit m_prio = 0, m_chk = 0, m_chk_rem = 0, m_stall = 0, m_cfail = 0, m_known = 0;
    // Per-cycle model predictions
    int e_gnt;
    bit e_push, e_pop, e_rem, e_deq_valid, e_cancel_ready, e_contended;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic void model_comb();
        bit popc, canc, cancel_wins;
        int i;
        e_gnt = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            i = (m_rr + k) % NUM_REQ;
            if (e_gnt < 0 && bus.req_valid[i]) e_gnt = i;
        end
        e_push         = !reset && !bus.q_full && (e_gnt >= 0);
        popc           = !m_chk && !bus.q_empty && bus.deq_ready;
        canc           = !m_chk && bus.cancel_valid;
        cancel_wins    = canc && (!popc || m_prio);
        e_contended    = popc && canc;
        e_deq_valid    = !reset && !m_chk && !bus.q_empty && !cancel_wins;
        e_cancel_ready = !reset && cancel_wins;
        e_pop          = e_deq_valid && bus.deq_ready;
        e_rem          = e_cancel_ready;
    endfunction

    task automatic compare();
        logic [NUM_REQ-1:0] exp_ready;
        logic [DATA_SIZE-1:0] exp_pdata;
        model_comb();
        exp_ready = '0;
        exp_pdata = '0;
        if (e_push) begin
            exp_ready[e_gnt] = 1'b1;
            exp_pdata = bus.req_data[e_gnt*DATA_SIZE +: DATA_SIZE];
        end
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("q_push_flag", 64'(bus.q_push_flag), 64'(e_push));
        if (e_push) chk("q_push_data", 64'(bus.q_push_data), 64'(exp_pdata));
        chk("deq_valid", 64'(bus.deq_valid), 64'(e_deq_valid));
        chk("deq_data", 64'(bus.deq_data), 64'(bus.q_pop_data));
        chk("cancel_ready", 64'(bus.cancel_ready), 64'(e_cancel_ready));
        chk("q_pop_flag", 64'(bus.q_pop_flag), 64'(e_pop));
        chk("q_remove_flag", 64'(bus.q_remove_flag), 64'(e_rem));
        chk("pop_rem_excl", 64'(bus.q_pop_flag & bus.q_remove_flag), 64'(0));
        if (e_rem) chk("q_remove_index", 64'(bus.q_remove_index), 64'(bus.cancel_index));
        if (m_known) begin
            chk("grant_id", 64'(grant_id), 64'(m_gid));
            chk("pop_stall", 64'(pop_stall), 64'(m_stall));
            chk("cancel_fail", 64'(cancel_fail), 64'(m_cfail));
`ifdef QUEUE_SCHED_STATS_EN
            chk("push_count", 64'(push_count), 64'(m_push_n));
            chk("pop_count", 64'(pop_count), 64'(m_pop_n));
            chk("fail_count", 64'(fail_count), 64'(m_fail_n));
`else
            chk("push_count", 64'(push_count), 64'(0));
            chk("pop_count", 64'(pop_count), 64'(0));
            chk("fail_count", 64'(fail_count), 64'(0));
`endif
        end
    endtask

    function automatic void model_edge();
        if (reset) begin
            m_rr = 0; m_gid = 0; m_prio = 0; m_chk = 0; m_chk_rem = 0;
            m_stall = 0; m_cfail = 0; m_push_n = 0; m_pop_n = 0; m_fail_n = 0;
            m_known = 1;
        end else begin
            if (e_push) begin
                m_gid = e_gnt;
                m_rr = (e_gnt + 1) % NUM_REQ;
                m_push_n = sat(m_push_n + 1);
            end
            m_cfail = 0;
            if (m_chk) begin
                if (!m_chk_rem && bus.q_error_time) begin
                    m_stall = 1;
                    m_fail_n = sat(m_fail_n + 1);
                end
                if (m_chk_rem && bus.q_error_rem) begin
                    m_cfail = 1;
                    m_fail_n = sat(m_fail_n + 1);
                end
                m_chk = 0;
            end else if (e_pop || e_rem) begin
                m_chk = 1;
                m_chk_rem = e_rem;
                if (e_pop) m_pop_n = sat(m_pop_n + 1);
                if (e_contended) m_prio = !m_prio;
            end
        end
    endfunction

    // Inputs are driven at the falling edge; outputs checked 2 time units later
    task automatic cyc_check();
        #2;
        compare();
    endtask

    task automatic cyc_end();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.cancel_valid = 1'b0;
        bus.cancel_index = '0;
        bus.deq_ready = 1'b0;
        bus.q_pop_data = '0;
        bus.q_full = 1'b0;
        bus.q_empty = 1'b1;
        bus.q_error_time = 1'b0;
        bus.q_error_rem = 1'b0;
    endtask

    task automatic rand_data();
        for (int r = 0; r < NUM_REQ; r++) bus.req_data[r*DATA_SIZE +: DATA_SIZE] = $urandom;
        bus.q_pop_data = $urandom;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);

        // Reset values
        for (int c = 0; c < 2; c++) begin
            bus.req_valid = 4'hF;
            cyc_check();
            chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
            cyc_end();
        end
        reset = 1'b0;
        idle_inputs();
        cyc_check();
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_pop_stall", 64'(pop_stall), 64'(0));
        cyc_end();

        // All requesters active: grants rotate 0,1,2,3,0,1,2,3
        bus.req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            rand_data();
            cyc_check();
            chk("rr_ready_lit", 64'(bus.req_ready), 64'(4'b0001 << (c % 4)));
            chk("rr_push_lit", 64'(bus.q_push_flag), 64'(1));
            chk("rr_pdata_lit", 64'(bus.q_push_data), 64'(bus.req_data[(c % 4)*DATA_SIZE +: DATA_SIZE]));
            cyc_end();
        end

        // Queue full blocks pushes and freezes the pointer
        bus.q_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc_check();
            chk("full_ready_lit", 64'(bus.req_ready), 64'(0));
            chk("full_push_lit", 64'(bus.q_push_flag), 64'(0));
            cyc_end();
        end
        bus.q_full = 1'b0;
        cyc_check();
        chk("full_resume_lit", 64'(bus.req_ready), 64'(4'b0001));
        cyc_end();
        bus.req_valid = '0;

        // Pop and cancel contend continuously: pop, CHECK, remove, CHECK, ...
        bus.q_empty = 1'b0;
        bus.deq_ready = 1'b1;
        bus.cancel_valid = 1'b1;
        bus.cancel_index = 10'd3;
        for (int c = 0; c < 8; c++) begin
            rand_data();
            cyc_check();
            chk("alt_pop_lit", 64'(bus.q_pop_flag), 64'((c % 4) == 0));
            chk("alt_rem_lit", 64'(bus.q_remove_flag), 64'((c % 4) == 2));
            cyc_end();
        end

        // Pop followed by an error-time indication makes pop_stall sticky
        bus.cancel_valid = 1'b0;
        bus.q_error_time = 1'b1;
        cyc_check();
        chk("stall_pop_lit", 64'(bus.q_pop_flag), 64'(1));
        cyc_end();
        bus.deq_ready = 1'b0;
        cyc_check();
        cyc_end();
        bus.q_error_time = 1'b0;
        for (int c = 0; c < 4; c++) begin
            cyc_check();
            chk("stall_lit", 64'(pop_stall), 64'(1));
`ifdef QUEUE_SCHED_STATS_EN
            chk("stall_fail_lit", 64'(fail_count), 64'(1));
`endif
            cyc_end();
        end
        reset = 1'b1;
        cyc_check();
        cyc_end();
        reset = 1'b0;
        idle_inputs();
        cyc_check();
        chk("stall_clr_lit", 64'(pop_stall), 64'(0));
        cyc_end();

        // Remove index 5 with error: cancel_fail pulses for exactly one cycle
        bus.cancel_valid = 1'b1;
        bus.cancel_index = 10'd5;
        bus.q_error_rem = 1'b1;
        cyc_check();
        chk("rem5_flag_lit", 64'(bus.q_remove_flag), 64'(1));
        chk("rem5_idx_lit", 64'(bus.q_remove_index), 64'(5));
        cyc_end();
        bus.cancel_valid = 1'b0;
        cyc_check();
        chk("cfail_pre_lit", 64'(cancel_fail), 64'(0));
        cyc_end();
        cyc_check();
        chk("cfail_pulse_lit", 64'(cancel_fail), 64'(1));
        cyc_end();
        cyc_check();
        chk("cfail_post_lit", 64'(cancel_fail), 64'(0));
        cyc_end();

        // Reset while in CHECK discards the pending error
        bus.cancel_valid = 1'b1;
        cyc_check();
        cyc_end();
        bus.cancel_valid = 1'b0;
        reset = 1'b1;
        cyc_check();
        cyc_end();
        reset = 1'b0;
        cyc_check();
        chk("rst_chk_cfail_lit", 64'(cancel_fail), 64'(0));
        chk("rst_chk_gid_lit", 64'(grant_id), 64'(0));
        chk("rst_chk_stall_lit", 64'(pop_stall), 64'(0));
        cyc_end();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            bus.req_valid = 4'($urandom);
            rand_data();
            bus.cancel_valid = ($urandom_range(0, 2) == 0);
            bus.cancel_index = 10'($urandom);
            bus.deq_ready = ($urandom_range(0, 3) != 0);
            bus.q_full = ($urandom_range(0, 3) == 0);
            bus.q_empty = ($urandom_range(0, 3) == 0);
            bus.q_error_time = ($urandom_range(0, 3) == 0);
            bus.q_error_rem = ($urandom_range(0, 2) == 0);
            cyc_check();
            cyc_end();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/queue_sched.md
QUEUE_SCHED -- requirements
Module: queue_sched

Interface
REQ-001 SHALL provide parameters: DATA_SIZE, default 32, entry width; NUM_REQ, default 4, push requesters (power of 2, >=2); PTR_WIDTH, default 10, queue index width; ID_WIDTH, default $clog2(NUM_REQ), grant id width.
REQ-002 SHALL use one clock and a synchronous, active-high reset: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-003 SHALL provide requester ports: req_valid in NUM_REQ, push requests; req_data in NUM_REQ*DATA_SIZE, requester i at bits [i*DATA_SIZE +: DATA_SIZE]; req_ready out NUM_REQ, one-hot accept.
REQ-004 SHALL provide cancel ports: cancel_valid in 1; cancel_index in PTR_WIDTH; cancel_ready out 1.
REQ-005 SHALL provide consumer ports: deq_valid out 1; deq_data out DATA_SIZE; deq_ready in 1.
REQ-006 SHALL provide queue-side ports: q_push_flag out 1; q_push_data out DATA_SIZE; q_pop_flag out 1; q_pop_data in DATA_SIZE; q_remove_flag out 1; q_remove_index out PTR_WIDTH; q_full in 1; q_empty in 1; q_error_time in 1; q_error_rem in 1.
REQ-007 SHALL provide status ports: grant_id out ID_WIDTH, last granted requester; pop_stall out 1, sticky error-time flag; cancel_fail out 1, one-cycle pulse; push_count, pop_count, fail_count out 16 each.

Function
REQ-008 SHALL accept at most one push per cycle, only when q_full=0.
REQ-009 SHALL grant push round-robin: lowest index i at or after rr_ptr (mod NUM_REQ) with req_valid[i]=1; req_ready is one-hot on i, all zero if q_full=1 or no request.
REQ-010 SHALL, on grant, drive q_push_flag=1 and q_push_data=req_data slice i combinationally, register grant_id<=i, and set rr_ptr<=(i+1) mod NUM_REQ; rr_ptr SHALL hold when no grant.
REQ-011 SHALL implement a two-state FSM, IDLE and CHECK; pop and remove SHALL be issued only in IDLE.
REQ-012 SHALL drive deq_valid=1 only in IDLE with q_empty=0 when pop owns the slot (REQ-014); deq_data=q_pop_data combinationally.
REQ-013 SHALL drive cancel_ready=1 only in IDLE when cancel owns the slot; q_remove_flag=cancel_valid&cancel_ready, q_remove_index=cancel_index.
REQ-014 SHALL never assert q_pop_flag and q_remove_flag in the same cycle; if a pop candidate (q_empty=0, deq_ready=1) and cancel_valid are both present, the owner SHALL be given by a prio token (0=pop, 1=cancel), toggled after each contended win; a lone contender SHALL win regardless of token.
REQ-015 SHALL assert q_pop_flag on deq_valid&deq_ready and SHALL enter CHECK the next cycle; a remove SHALL also enter CHECK.
REQ-016 SHALL, in CHECK, sample q_error_time (after pop) and set pop_stall<=1 if high, or sample q_error_rem (after remove) and pulse cancel_fail next cycle if high; CHECK SHALL always return to IDLE after one cycle.
REQ-017 SHALL continue push arbitration in both IDLE and CHECK, independent of pop/remove.
REQ-018 SHALL clear pop_stall only by reset.
REQ-019 SHALL saturate counters at 16'hFFFF: push_count per push, pop_count per pop, fail_count per error_time or error_rem detected in CHECK.

Reset
REQ-020 SHALL, while reset=1 at a clk edge, set state=IDLE, rr_ptr=0, prio token=0, grant_id=0, pop_stall=0, cancel_fail=0, all counters=0.
REQ-021 SHALL force req_ready, cancel_ready, deq_valid, q_push_flag, q_pop_flag and q_remove_flag to 0 combinationally while reset=1.
REQ-022 SHALL, on reset mid-CHECK, discard the pending check (no flag, no pulse).

Configuration
REQ-023 SHALL compile the counters of REQ-019 only when QUEUE_SCHED_STATS_EN is defined; when undefined, push_count, pop_count and fail_count SHALL be constant 0 with no registers inferred, and all other behaviour SHALL be unchanged.

Verification
REQ-024 SHALL cover: all four req_valid=1 for 8 cycles, q_full=0 -> grants 0,1,2,3,0,1,2,3, one q_push_flag per cycle.
REQ-025 SHALL cover: q_full=1 with req_valid=4'b1111 -> req_ready=0, q_push_flag=0, rr_ptr unchanged.
REQ-026 SHALL cover: q_empty=0, deq_ready=1, cancel_valid=1 held for 8 cycles -> pop, CHECK, remove, CHECK, pop, ...; never both flags in one cycle.
REQ-027 SHALL cover: pop accepted, q_error_time=1 in CHECK -> pop_stall=1 until reset; fail_count=1 with QUEUE_SCHED_STATS_EN.
REQ-028 SHALL cover: remove index 5 with q_error_rem=1 in CHECK -> cancel_fail high exactly one cycle; reset asserted in CHECK -> no pulse, all outputs at REQ-020 values.
